log2: RTL and testbench

- Fully pipelined unsigned base-2 logarithm unit.
- Accepts one 8-bit integer sample per clock with a valid strobe.
- Returns log2(x) in unsigned fixed point: 3 integer bits, FRAC_W fractional bits.
- Fixed latency; the output valid strobe is the input strobe delayed by that latency. Used as a streaming math primitive in datapaths.

---
 rtl/log2.sv | 144 ++++++++++++++
 tb/tb_log2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/log2.sv
// ---------------------------------------------------------------------------
// log2 : fully pipelined unsigned base-2 logarithm of an 8-bit integer.
//
// Result format is Q3.FRAC_W: y[FRAC_W+2:FRAC_W] is the integer part
// (index of the leading one), y[FRAC_W-1:0] the truncated fraction.
// One sample per clock, fixed latency FRAC_W+2 from validx to validy.
//
// Pipeline:
//   capture   : register x and validx
//   normalise : leading-one index e, mantissa m = x << (7-e) in 1.(MANT_W-1)
//   square k  : k = 1..FRAC_W, one fraction bit each (MSB first):
//               p = m*m; p >= 2 -> bit 1, m = p/2; else bit 0, m = p
//               (m truncated back to MANT_W bits, never rounded)
//   output    : y / validy registers; y holds when no valid result arrives
//
// x = 0 flows through as e = 0, m = 0 and therefore yields y = 0.
//
// Optional feature (macro LOG2_ZERO_FLAG_EN): adds output zero_err, set
// together with validy when the delivered result came from x = 0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (clears all valid flags)
//   x        in   8-bit unsigned operand, sampled when validx = 1
//   validx   in   input strobe, no backpressure
//   y        out  Q3.FRAC_W result
//   validy   out  y carries a new result this cycle
//   zero_err out  (LOG2_ZERO_FLAG_EN only) result came from x = 0
//
// Handshake: validx/validy are one-cycle strobes with no ready signal; every
// sample presented with validx = 1 produces exactly one validy pulse
// FRAC_W+2 cycles later, in order, unless a reset intervenes.
// ---------------------------------------------------------------------------
module log2 #(
  parameter int FRAC_W = 5,
  parameter int MANT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        x,
  input  logic              validx,
  output logic [FRAC_W+2:0] y,
  output logic              validy
`ifdef LOG2_ZERO_FLAG_EN
  ,
  output logic              zero_err
`endif
);

  localparam int PW = 2 * MANT_W;

  // Capture stage
  logic [7:0] cap_x;
  logic       cap_v;

  // Normalisation (combinational from the capture registers)
  logic [2:0] lead_e;
  logic [7:0] lead_sh;

  always_comb begin
    lead_e = '0;
    for (int i = 0; i < 8; i++) begin
      if (cap_x[i]) lead_e = 3'(i);
    end
    lead_sh = cap_x << (3'd7 - lead_e);
  end

  // Stage registers: index 0 is the normalised stage, 1..FRAC_W the squarers
  logic [MANT_W-1:0] m_q [0:FRAC_W];
  logic [2:0]        e_q [0:FRAC_W];
  logic [FRAC_W-1:0] f_q [0:FRAC_W];
  logic              v_q [0:FRAC_W];

  // Squaring stage next values
  logic [MANT_W-1:0] m_d  [1:FRAC_W];
  logic [FRAC_W-1:0] f_d  [1:FRAC_W];
  logic              hi_d [1:FRAC_W];

  always_comb begin
    for (int k = 1; k <= FRAC_W; k++) begin
      // m is in [1,2) so m*m is in [1,4); its top bit means p >= 2.
      hi_d[k] = (PW'(m_q[k-1]) * PW'(m_q[k-1])) >= (PW'(1) << (PW - 1));
      // Dropping MANT_W-1 low bits rescales back to 1.(MANT_W-1); one more
      // bit of shift is the divide-by-two when p >= 2.
      m_d[k]  = MANT_W'((PW'(m_q[k-1]) * PW'(m_q[k-1]))
                        >> (hi_d[k] ? MANT_W : MANT_W - 1));
      f_d[k]  = f_q[k-1];
      if (hi_d[k]) f_d[k][FRAC_W-k] = 1'b1;
    end
  end

`ifdef LOG2_ZERO_FLAG_EN
  logic z_q [0:FRAC_W];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_x  <= '0;
      cap_v  <= 1'b0;
      for (int k = 0; k <= FRAC_W; k++) begin
        m_q[k] <= '0;
        e_q[k] <= '0;
        f_q[k] <= '0;
        v_q[k] <= 1'b0;
`ifdef LOG2_ZERO_FLAG_EN
        z_q[k] <= 1'b0;
`endif
      end
      y      <= '0;
      validy <= 1'b0;
`ifdef LOG2_ZERO_FLAG_EN
      zero_err <= 1'b0;
`endif
    end else begin
      cap_x  <= x;
      cap_v  <= validx;

      m_q[0] <= {lead_sh, (MANT_W-8)'(0)};
      e_q[0] <= lead_e;
      f_q[0] <= '0;
      v_q[0] <= cap_v;
`ifdef LOG2_ZERO_FLAG_EN
      z_q[0] <= (cap_x == 8'd0);
`endif

      for (int k = 1; k <= FRAC_W; k++) begin
        m_q[k] <= m_d[k];
        e_q[k] <= e_q[k-1];
        f_q[k] <= f_d[k];
        v_q[k] <= v_q[k-1];
`ifdef LOG2_ZERO_FLAG_EN
        z_q[k] <= z_q[k-1];
`endif
      end

      validy <= v_q[FRAC_W];
      if (v_q[FRAC_W]) y <= {e_q[FRAC_W], f_q[FRAC_W]};
`ifdef LOG2_ZERO_FLAG_EN
      zero_err <= v_q[FRAC_W] & z_q[FRAC_W];
`endif
    end
  end

endmodule

// File: tb/tb_log2.sv
// ---------------------------------------------------------------------------
// tb_log2 : self-checking bench for log2 (default parameters).
// Driver tasks push the expected result and its due cycle into queues when a
// valid sample is issued; a free-running monitor compares every validy pulse
// against the queue head and checks that y holds between results.
// ---------------------------------------------------------------------------
module tb_log2;

  localparam int FRAC_W = 5;
  localparam int MANT_W = 16;
  localparam int LAT    = FRAC_W + 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic       validx;
  logic [7:0] y;
  logic       validy;
`ifdef LOG2_ZERO_FLAG_EN
  logic       zero_err;
`endif

  log2 #(.FRAC_W(FRAC_W), .MANT_W(MANT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x),
    .validx (validx),
    .y      (y),
    .validy (validy)
`ifdef LOG2_ZERO_FLAG_EN
    ,
    .zero_err(zero_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic       exp_z[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] held_y = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the squaring rules applied with plain 64-bit arithmetic.
  function automatic int ref_log2(input int xv);
    longint m, p;
    int     e, frac;
    if (xv == 0) return 0;
    e = 0;
    for (int i = 0; i < 8; i++) if (((xv >> i) & 1) != 0) e = i;
    m = longint'(xv) << (MANT_W - 1 - e);
    frac = 0;
    for (int k = 0; k < FRAC_W; k++) begin
      p = m * m;
      frac = frac * 2;
      if (p >= (longint'(1) << (2 * MANT_W - 1))) begin
        frac = frac + 1;
        m = p >> MANT_W;
      end else begin
        m = p >> (MANT_W - 1);
      end
    end
    return e * (1 << FRAC_W) + frac;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int xv, input bit v, input int ey);
    @(negedge clk);
    x = 8'(xv);
    validx = v;
    if (v && rst_n) begin
      exp_q.push_back(8'(ey));
      exp_t.push_back(cyc + 1 + LAT);
      exp_z.push_back(xv == 0);
    end
  endtask

  task automatic send_rand(input int xv);
    drive(xv, 1'b1, ref_log2(xv));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(int'($urandom_range(0, 255)), 1'b0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic r;
    cyc++;
    r = rst_n;
    #1;
    if (!r) begin
      chk("reset_validy", validy, 0);
      chk("reset_y", y, 0);
`ifdef LOG2_ZERO_FLAG_EN
      chk("reset_zero_err", zero_err, 0);
`endif
      held_y = '0;
    end else if (validy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_validy: got validy 1 with y %0d, expected no output (cycle %0d)", y, cyc);
      end else begin
        logic [7:0] ey;
        int         et;
        logic       ez;
        ey = exp_q.pop_front();
        et = exp_t.pop_front();
        ez = exp_z.pop_front();
        chk("y", y, ey);
        chk("latency", cyc, et);
`ifdef LOG2_ZERO_FLAG_EN
        chk("zero_err", zero_err, ez);
`endif
        held_y = ey;
      end
    end else begin
      chk("y_held", y, held_y);
`ifdef LOG2_ZERO_FLAG_EN
      chk("zero_err_idle", zero_err, 0);
`endif
      if (exp_t.size() > 0 && exp_t[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_validy: got validy 0, expected y %0d due at cycle %0d", exp_q[0], exp_t[0]);
        void'(exp_q.pop_front());
        void'(exp_t.pop_front());
        void'(exp_z.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    x      = '0;
    validx = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single sample after reset
    drive(2, 1'b1, 32);
    idle(10);

    // exact values, back to back
    drive(1,   1'b1, 0);
    drive(128, 1'b1, 224);
    drive(255, 1'b1, 255);
    drive(3,   1'b1, 50);
    drive(6,   1'b1, 82);
    idle(10);

    // streaming burst of random samples
    for (int i = 0; i < 6; i++) send_rand(int'($urandom_range(1, 255)));
    idle(12);

    // gap pattern 1,0,1,1,0
    send_rand(int'($urandom_range(1, 255)));
    idle(1);
    send_rand(int'($urandom_range(1, 255)));
    send_rand(int'($urandom_range(1, 255)));
    idle(1);
    idle(10);

    // zero input
    drive(0, 1'b1, 0);
    idle(10);

    // random mix of valid/idle cycles, occasional zeros
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 9) == 0) send_rand(0);
        else send_rand(int'($urandom_range(1, 255)));
      end else begin
        idle(1);
      end
    end
    idle(10);

    // reset while three samples are in flight
    send_rand(int'($urandom_range(1, 255)));
    send_rand(int'($urandom_range(1, 255)));
    send_rand(int'($urandom_range(1, 255)));
    @(negedge clk);
    rst_n  = 1'b0;
    validx = 1'b0;
    exp_q.delete();
    exp_t.delete();
    exp_z.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(16, 1'b1, 128);
    idle(12);

    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
